// File: rtl/systolic_feed_ctrl_pkg.sv
// ============================================================================
//  Module   : systolic_feed_ctrl_pkg
//  Purpose  : Shared FSM encoding and default geometry for the feed controller
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_feed_ctrl_pkg;

    localparam int c_default_data_width = 16;
    localparam int c_default_n          = 4;
    localparam int c_default_m          = 7;
    // The top exposes exactly four row/lane ports regardless of N.
    localparam int c_lane_ports         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_feed_ctrl_skew_delay_line.sv
// ============================================================================
//  Module   : skew_delay_line
//  Purpose  : Valid-qualified delay of DEPTH cycles; DEPTH=0 is a pass-through
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_vld    = i_vld;
            assign o_data   = i_vld ? i_data : '0;
        end else begin : g_shift
            logic [DEPTH-1:0]      r_vld_q;
            logic [DEPTH-1:0]      w_vld_d;
            logic [DATA_WIDTH-1:0] r_data_q [DEPTH];
            logic [DATA_WIDTH-1:0] w_data_d [DEPTH];

            // Data is zeroed on entry when invalid, so every stage reads 0 while its valid is low.
            always_comb begin
                w_vld_d[0]  = i_vld;
                w_data_d[0] = i_vld ? i_data : '0;
                for (int j = 1; j < DEPTH; j++) begin
                    w_vld_d[j]  = r_vld_q[j-1];
                    w_data_d[j] = r_data_q[j-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_q <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        r_data_q[j] <= '0;
                    end
                end else begin
                    r_vld_q  <= w_vld_d;
                    r_data_q <= w_data_d;
                end
            end

            assign o_vld  = r_vld_q[DEPTH-1];
            assign o_data = r_data_q[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_feed_ctrl.sv
// ============================================================================
//  Module   : systolic_feed_ctrl
//  Purpose  : Loads M*N host words into a row buffer, then streams the rows
//             out as a diagonally skewed wavefront for a systolic array.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int N          = c_default_n,
    parameter int M          = c_default_m
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  buf_wr,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic                  buf_rd,
    input  logic [DATA_WIDTH-1:0] row0,
    input  logic [DATA_WIDTH-1:0] row1,
    input  logic [DATA_WIDTH-1:0] row2,
    input  logic [DATA_WIDTH-1:0] row3,
    output logic [DATA_WIDTH-1:0] lane0,
    output logic [DATA_WIDTH-1:0] lane1,
    output logic [DATA_WIDTH-1:0] lane2,
    output logic [DATA_WIDTH-1:0] lane3,
    output logic [N-1:0]          lane_vld,
    output logic                  busy,
    output logic                  done
);

    localparam int c_word_w  = $clog2(M*N + 1);
    localparam int c_row_w   = $clog2(M + 1);
    localparam int c_flush_w = $clog2(N + 1);

    state_t                r_state_q,     w_state_d;
    logic [c_word_w-1:0]   r_word_cnt_q,  w_word_cnt_d;
    logic [c_row_w-1:0]    r_row_cnt_q,   w_row_cnt_d;
    logic [c_flush_w-1:0]  r_flush_cnt_q, w_flush_cnt_d;
    logic                  r_row_vld_q,   w_row_vld_d;

    logic [DATA_WIDTH-1:0] w_row  [c_lane_ports];
    logic [DATA_WIDTH-1:0] w_lane [c_lane_ports];

    always_comb begin
        w_state_d     = r_state_q;
        w_word_cnt_d  = r_word_cnt_q;
        w_row_cnt_d   = r_row_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        in_ready      = 1'b0;
        buf_wr        = 1'b0;
        buf_rd        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d    = ST_LOAD;
                    w_word_cnt_d = '0;
                    w_row_cnt_d  = '0;
                end
            end
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_wr       = 1'b1;
                    w_word_cnt_d = r_word_cnt_q + c_word_w'(1);
                    if (r_word_cnt_q == c_word_w'(M*N - 1)) begin
                        w_state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                busy        = 1'b1;
                buf_rd      = 1'b1;
                w_row_cnt_d = r_row_cnt_q + c_row_w'(1);
                if (r_row_cnt_q == c_row_w'(M - 1)) begin
                    w_state_d     = ST_FLUSH;
                    w_flush_cnt_d = '0;
                end
            end
            // One cycle of buffer latency plus N-1 cycles of skew drain.
            ST_FLUSH: begin
                busy          = 1'b1;
                w_flush_cnt_d = r_flush_cnt_q + c_flush_w'(1);
                if (r_flush_cnt_q == c_flush_w'(N - 1)) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_row_vld_d = buf_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_word_cnt_q  <= '0;
            r_row_cnt_q   <= '0;
            r_flush_cnt_q <= '0;
            r_row_vld_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_word_cnt_q  <= w_word_cnt_d;
            r_row_cnt_q   <= w_row_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
            r_row_vld_q   <= w_row_vld_d;
        end
    end

    assign buf_data = buf_wr ? in_data : '0;

    assign w_row[0] = row0;
    assign w_row[1] = row1;
    assign w_row[2] = row2;
    assign w_row[3] = row3;

    // Lane k adds k cycles so row r reaches array row k on the diagonal r+k.
    generate
        for (genvar k = 0; k < c_lane_ports; k++) begin : g_lane
            if (k < N) begin : g_used
                skew_delay_line #(
                    .DATA_WIDTH(DATA_WIDTH),
                    .DEPTH     (k)
                ) u_skew (
                    .clk   (clk),
                    .rst   (rst),
                    .i_vld (r_row_vld_q),
                    .i_data(w_row[k]),
                    .o_vld (lane_vld[k]),
                    .o_data(w_lane[k])
                );
            end else begin : g_tied
                assign w_lane[k] = '0;
            end
        end
        for (genvar k = c_lane_ports; k < N; k++) begin : g_extra_vld
            assign lane_vld[k] = 1'b0;
        end
    endgenerate

    assign lane0 = w_lane[0];
    assign lane1 = w_lane[1];
    assign lane2 = w_lane[2];
    assign lane3 = w_lane[3];

endmodule

`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
// ============================================================================
//  Module   : tb_systolic_feed_ctrl
//  Purpose  : Directed/randomized self-checking bench for systolic_feed_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_feed_ctrl;

    localparam int DW    = 16;
    localparam int NL    = 4;
    localparam int MR    = 7;
    localparam int WORDS = NL * MR;
    localparam int LIMIT = 300;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, buf_clr;
    logic [DW-1:0] in_data;
    logic          in_ready, buf_wr, buf_rd, busy, done;
    logic [DW-1:0] buf_data;
    logic [DW-1:0] row_q [NL];
    logic [DW-1:0] lane  [NL];
    logic [NL-1:0] lane_vld;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [NL-1:0] vhist    = '0;

    always #5 clk = ~clk;

    systolic_feed_ctrl #(.DATA_WIDTH(DW), .N(NL), .M(MR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .buf_wr(buf_wr), .buf_data(buf_data), .buf_rd(buf_rd),
        .row0(row_q[0]), .row1(row_q[1]), .row2(row_q[2]), .row3(row_q[3]),
        .lane0(lane[0]), .lane1(lane[1]), .lane2(lane[2]), .lane3(lane[3]),
        .lane_vld(lane_vld), .busy(busy), .done(done)
    );

    // Row buffer: stores written words in order, returns a whole row one cycle after buf_rd.
    logic [DW-1:0] mem [WORDS];
    int            wptr, rptr;
    always @(posedge clk) begin
        if (buf_clr) begin
            wptr <= 0;
            rptr <= 0;
        end else begin
            if (buf_wr && wptr < WORDS) begin
                mem[wptr] <= buf_data;
                wptr      <= wptr + 1;
            end
            if (buf_rd && rptr < MR) rptr <= rptr + 1;
        end
        for (int k = 0; k < NL; k++)
            row_q[k] <= (buf_rd && rptr < MR) ? mem[rptr*NL + k] : DW'($urandom);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called exactly once per cycle so the lane_vld[0] history stays aligned.
    task automatic check_cycle(input string ph, input logic [4:0] ectrl,
                               input logic [NL-1:0] evld, input logic [NL*DW-1:0] elanes);
        logic [NL*DW-1:0] olanes;
        for (int k = 0; k < NL; k++) olanes[k*DW +: DW] = lane[k];
        vhist = {vhist[NL-2:0], lane_vld[0]};
        check({ph, "_ctrl"}, 64'({in_ready, buf_wr, buf_rd, busy, done}), 64'(ectrl));
        check({ph, "_lane_vld"}, 64'(lane_vld), 64'(evld));
        check({ph, "_lanes"}, olanes, elanes);
        check({ph, "_wr_rd_excl"}, 64'(buf_wr & buf_rd), 64'(0));
        check({ph, "_vld_skew"}, 64'(lane_vld), 64'(vhist));
    endtask

    task automatic idle_cycles(input int n, input string ph);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start    = 1'b0;
            buf_clr  = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            #1;
            check_cycle(ph, 5'b0, '0, '0);
        end
    endtask

    // mode 0: words 1..N*M back to back; 1: in_valid toggles 1/0; 2: random gaps plus
    // spurious start/in_valid; 3: reset after 10 accepted words; 4: random gaps.
    task automatic run_job(input int mode, input string ph);
        logic [DW-1:0]    w [WORDS];
        logic [NL-1:0]    evld;
        logic [NL*DW-1:0] elanes;
        logic             e_load, e_wr, e_rd, e_busy, e_done, ev, finished, aborted;
        int               acc, tr, r, n_load, n_wr, n_rd, n_done, done_at;

        for (int i = 0; i < WORDS; i++) w[i] = (mode == 0) ? DW'(i + 1) : DW'($urandom);
        acc = 0; tr = -1; n_load = 0; n_wr = 0; n_rd = 0; n_done = 0; done_at = -1;
        finished = 1'b0; aborted = 1'b0;

        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (mode == 3 && acc == 10) begin
                aborted = 1'b1;
                break;
            end
            e_load  = (c >= 1) && (acc < WORDS);
            start   = (c == 0) || (mode == 2 && tr >= 0 && c >= tr && c < tr + MR);
            buf_clr = (c == 0);
            if (e_load) begin
                case (mode)
                    0, 3:    ev = 1'b1;
                    1:       ev = ((c - 1) % 2 == 0);
                    default: ev = 1'($urandom_range(0, 1));
                endcase
                in_valid = ev;
                in_data  = ev ? w[acc] : DW'($urandom);
            end else begin
                in_valid = (mode == 2);
                in_data  = DW'($urandom);
            end
            #1;
            e_wr   = e_load && in_valid;
            e_rd   = (tr >= 0) && (c >= tr) && (c < tr + MR);
            e_done = (tr >= 0) && (c == tr + MR + NL);
            e_busy = (c >= 1) && !((tr >= 0) && (c >= tr + MR + NL));
            elanes = '0;
            for (int k = 0; k < NL; k++) begin
                r       = c - (tr + 1 + k);
                evld[k] = (tr >= 0) && (r >= 0) && (r < MR);
                if (evld[k]) elanes[k*DW +: DW] = w[r*NL + k];
            end
            check_cycle(ph, {e_load, e_wr, e_rd, e_busy, e_done}, evld, elanes);
            if (e_wr) check({ph, "_buf_data"}, 64'(buf_data), 64'(w[acc]));
            n_load += int'(e_load);
            n_wr   += int'(buf_wr === 1'b1);
            n_rd   += int'(buf_rd === 1'b1);
            if (done === 1'b1) begin
                n_done++;
                done_at = c;
            end
            if (e_wr) begin
                acc++;
                if (acc == WORDS) tr = c + 1;
            end
            if (e_done) begin
                finished = 1'b1;
                break;
            end
        end

        if (aborted) begin
            rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = DW'($urandom);
            #1;
            check_cycle({ph, "_rst_cycle"}, 5'b10010, '0, '0);
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b1;
            #1;
            check_cycle({ph, "_after_rst"}, 5'b0, '0, '0);
            check({ph, "_wr_count"}, 64'(n_wr), 64'(10));
            idle_cycles(4, {ph, "_idle"});
        end else begin
            check({ph, "_finished"}, 64'(finished), 64'(1));
            check({ph, "_wr_count"}, 64'(n_wr), 64'(WORDS));
            check({ph, "_rd_count"}, 64'(n_rd), 64'(MR));
            check({ph, "_done_count"}, 64'(n_done), 64'(1));
            check({ph, "_done_cycle"}, 64'(done_at), 64'(1 + n_load + MR + NL));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; buf_clr = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycles(4, "reset_idle");

        run_job(0, "full");
        idle_cycles(2, "gap1");
        run_job(1, "stall");
        idle_cycles(2, "gap2");
        run_job(2, "spurious");
        idle_cycles(3, "post_spurious");
        run_job(3, "abort");
        run_job(4, "fresh");
        for (int j = 0; j < 3; j++) begin
            idle_cycles(1 + j, "gap_rand");
            run_job(4, "random");
        end
        idle_cycles(2, "tail");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
